// File: rtl/ibuf_pkg.sv
// Shared definitions for the input-buffer bank array: read modes, fill FSM states
// and the geometry defaults also used by the data router.
package ibuf_pkg;

    localparam int unsigned IBUF_POY   = 3;
    localparam int unsigned IBUF_ROWS  = 4;
    localparam int unsigned IBUF_DEPTH = 64;
    localparam int unsigned IBUF_DW    = 16;
    localparam int unsigned IBUF_COL_W = 28;

    typedef enum logic [1:0] {
        RR = 2'b00,
        BR = 2'b01,
        RP = 2'b10,
        NE = 2'b11
    } rmode_e;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } ibuf_state_e;

    // Bank is only meaningful (and only range-checked) in the single-bank modes.
    function automatic logic req_out_of_range(
        input rmode_e      mode,
        input logic [1:0]  bank_sel,
        input logic [1:0]  row_sel,
        input logic        col_hi_nz,
        input int unsigned poy,
        input int unsigned rows
    );
        logic bank_bad;
        bank_bad = ((mode == BR) || (mode == RP)) && (32'(bank_sel) >= poy);
        return bank_bad || (32'(row_sel) >= rows) || col_hi_nz;
    endfunction

endpackage

// File: rtl/ibuf_bank_ram.sv
// One bank of pixel storage: 1R1W synchronous RAM, one-cycle read latency,
// a read and write to the same word in one cycle returns the old contents.
module ibuf_bank_ram #(
    parameter int unsigned DW    = 16,
    parameter int unsigned WORDS = 256,
    parameter int unsigned AWID  = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AWID-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [AWID-1:0] raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ibuf_bank_array.sv
// Banked input buffer: filled one block at a time by the loader, then serves
// POY-lane read requests with a fixed three-stage pipeline until released.
module ibuf_bank_array
    import ibuf_pkg::*;
#(
    parameter int unsigned POY   = IBUF_POY,
    parameter int unsigned ROWS  = IBUF_ROWS,
    parameter int unsigned DEPTH = IBUF_DEPTH,
    parameter int unsigned DW    = IBUF_DW,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DW-1:0]         wdata,
    output logic                  blkend,
    input  logic                  blk_rel,
    input  logic [1:0]            rpsel,
    input  logic [1:0]            bank,
    input  logic [1:0]            row,
    input  logic [IBUF_COL_W-1:0] col,
    output logic [POY*DW-1:0]     rdata,
    output logic                  rvalid,
    output logic [POY-1:0]        rmask,
    output logic                  rerr
);

    localparam int unsigned RAW = $clog2(ROWS * DEPTH);

    ibuf_state_e     state;
    logic            blk_first;
    logic [1:0]      w_bank;
    logic [1:0]      w_row;
    logic [AW-1:0]   w_col;
    logic            w_fire;
    logic            last_col;
    logic            last_row;
    logic            last_bank;
    logic [RAW-1:0]  w_addr;

    assign w_fire    = wvalid && wready;
    assign last_col  = (w_col == AW'(DEPTH - 1));
    assign last_row  = (w_row == 2'(ROWS - 1));
    assign last_bank = (w_bank == 2'(POY - 1));
    assign w_addr    = RAW'(w_row) * RAW'(DEPTH) + RAW'(w_col);
    assign blkend    = (state == READY) && blk_first;

    // Write counter walks col fastest, then row, then bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wready    <= 1'b0;
            blk_first <= 1'b0;
            w_bank    <= '0;
            w_row     <= '0;
            w_col     <= '0;
        end else begin
            blk_first <= 1'b0;
            case (state)
                FILL: begin
                    wready <= 1'b1;
                    if (w_fire) begin
                        if (!last_col) begin
                            w_col <= w_col + 1'b1;
                        end else begin
                            w_col <= '0;
                            if (!last_row) begin
                                w_row <= w_row + 1'b1;
                            end else begin
                                w_row <= '0;
                                if (!last_bank) begin
                                    w_bank <= w_bank + 1'b1;
                                end else begin
                                    w_bank    <= '0;
                                    state     <= READY;
                                    wready    <= 1'b0;
                                    blk_first <= 1'b1;
                                end
                            end
                        end
                    end
                end
                READY: begin
                    if (blk_rel) begin
                        state  <= FILL;
                        wready <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    rmode_e          req_mode;
    logic            req_err;
    logic            s0_vld;
    logic            s0_err;
    rmode_e          s0_mode;
    logic [1:0]      s0_bank;
    logic [RAW-1:0]  s0_addr;

    assign req_mode = rmode_e'(rpsel);
    assign req_err  = req_out_of_range(req_mode, bank, row, |col[IBUF_COL_W-1:AW], POY, ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s0_err  <= 1'b0;
            s0_mode <= NE;
            s0_bank <= '0;
            s0_addr <= '0;
        end else begin
            s0_vld  <= (req_mode != NE);
            s0_err  <= req_err;
            s0_mode <= req_mode;
            s0_bank <= bank;
            s0_addr <= RAW'(row) * RAW'(DEPTH) + RAW'(col[AW-1:0]);
        end
    end

    logic [DW-1:0] ram_q [POY];

    for (genvar i = 0; i < POY; i++) begin : g_bank
        logic we;
        logic re;
        assign we = w_fire && (w_bank == 2'(i));
        // Out-of-range requests never touch the RAM.
        assign re = s0_vld && !s0_err && ((s0_mode == RR) || (s0_bank == 2'(i)));

        ibuf_bank_ram #(
            .DW    (DW),
            .WORDS (ROWS * DEPTH),
            .AWID  (RAW)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (w_addr),
            .wdata (wdata),
            .re    (re),
            .raddr (s0_addr),
            .rdata (ram_q[i])
        );
    end

    logic       s1_vld;
    logic       s1_err;
    rmode_e     s1_mode;
    logic [1:0] s1_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_err  <= 1'b0;
            s1_mode <= NE;
            s1_bank <= '0;
        end else begin
            s1_vld  <= s0_vld;
            s1_err  <= s0_err;
            s1_mode <= s0_mode;
            s1_bank <= s0_bank;
        end
    end

    logic [DW-1:0]     sel_word;
    logic [POY*DW-1:0] lane_d;
    logic [POY-1:0]    mask_d;

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < POY; i++) begin
            if (s1_bank == 2'(i)) begin
                sel_word = ram_q[i];
            end
        end
        lane_d = '0;
        mask_d = '0;
        case (s1_mode)
            RR: begin
                for (int unsigned i = 0; i < POY; i++) begin
                    lane_d[i*DW +: DW] = ram_q[i];
                end
                mask_d = '1;
            end
            BR: begin
                lane_d[(POY-1)*DW +: DW] = sel_word;
                mask_d[POY-1]            = 1'b1;
            end
            RP: begin
                lane_d[DW-1:0] = sel_word;
                mask_d[0]      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A no-read slot leaves rdata at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            rmask  <= '0;
            rerr   <= 1'b0;
        end else begin
            rvalid <= s1_vld;
            if (s1_vld && s1_err) begin
                rdata <= '0;
                rmask <= '0;
                rerr  <= 1'b1;
            end else if (s1_vld) begin
                rdata <= lane_d;
                rmask <= mask_d;
                rerr  <= 1'b0;
            end else begin
                rmask <= '0;
                rerr  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ibuf_bank_array.sv
// Self-checking bench for ibuf_bank_array: directed scenarios plus randomized
// fills and reads compared against a block-level reference model.
module tb_ibuf_bank_array;

    localparam int POY   = 3;
    localparam int ROWS  = 4;
    localparam int DEPTH = 64;
    localparam int TOTAL = POY * ROWS * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wvalid = 1'b0;
    logic [15:0] wdata = '0;
    logic        blk_rel = 1'b0;
    logic [1:0]  rpsel = 2'b11;
    logic [1:0]  bank = '0;
    logic [1:0]  row = '0;
    logic [27:0] col = '0;
    logic        wready;
    logic        blkend;
    logic [47:0] rdata;
    logic        rvalid;
    logic [2:0]  rmask;
    logic        rerr;

    ibuf_bank_array #(
        .POY   (3),
        .ROWS  (4),
        .DEPTH (64),
        .DW    (16),
        .AW    (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .blkend  (blkend),
        .blk_rel (blk_rel),
        .rpsel   (rpsel),
        .bank    (bank),
        .row     (row),
        .col     (col),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rmask   (rmask),
        .rerr    (rerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          err;
        logic [2:0]  mask;
        logic [47:0] data;
        int          due;
    } resp_t;

    logic [15:0] mdl [POY][ROWS][DEPTH];
    int          wcount;
    bit          m_fill;
    bit          m_wready;
    bit          m_blk;
    logic [47:0] held;
    resp_t       expq[$];
    resp_t       cur;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [15:0] pattern(int k);
        int b, r, c;
        b = k / (ROWS * DEPTH);
        r = (k / DEPTH) % ROWS;
        c = k % DEPTH;
        return {4'(b), 4'(r), 8'(c)};
    endfunction

    function automatic resp_t model_read(int mode, int b, int r, logic [27:0] c);
        resp_t       x;
        logic [21:0] hi;
        int          cc;
        x.valid = 0; x.err = 0; x.mask = '0; x.data = '0; x.due = 0;
        if (mode == 3) return x;
        x.valid = 1;
        hi = c[27:6];
        cc = int'(c[5:0]);
        if (((mode == 1 || mode == 2) && b >= POY) || r >= ROWS || hi != 0) begin
            x.err = 1;
            return x;
        end
        case (mode)
            0: begin
                for (int i = 0; i < POY; i++) x.data[i*16 +: 16] = mdl[i][r][cc];
                x.mask = 3'b111;
            end
            1: begin
                x.data[47:32] = mdl[b][r][cc];
                x.mask = 3'b100;
            end
            default: begin
                x.data[15:0] = mdl[b][r][cc];
                x.mask = 3'b001;
            end
        endcase
        return x;
    endfunction

    task automatic model_reset();
        wcount = 0; m_fill = 1; m_wready = 0; m_blk = 0;
        expq.delete();
        held = '0;
        cur.valid = 0; cur.err = 0; cur.mask = '0; cur.data = '0; cur.due = 0;
    endtask

    // One clock: capture driven inputs, advance, update the block-level model.
    task automatic advance();
        bit          hs, rel;
        int          m, b, r;
        logic [27:0] c;
        logic [15:0] wd;
        resp_t       e;
        hs = wvalid && m_wready;
        rel = blk_rel;
        wd = wdata;
        m = int'(rpsel); b = int'(bank); r = int'(row); c = col;
        @(posedge clk);
        #1;
        cyc++;
        if (m_fill) begin
            m_blk = 0;
            if (hs) begin
                mdl[wcount / (ROWS * DEPTH)][(wcount / DEPTH) % ROWS][wcount % DEPTH] = wd;
                wcount++;
                if (wcount == TOTAL) begin
                    wcount = 0; m_fill = 0; m_blk = 1;
                end
            end
        end else begin
            m_blk = 0;
            if (rel) m_fill = 1;
        end
        m_wready = m_fill;
        e = model_read(m, b, r, c);
        e.due = cyc + 2;
        expq.push_back(e);
        while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
        if (expq.size() > 0 && expq[0].due == cyc) begin
            cur = expq.pop_front();
        end else begin
            cur.valid = 0; cur.err = 0; cur.mask = '0; cur.due = cyc;
        end
        if (cur.valid) held = cur.data;
        else cur.data = held;
    endtask

    task automatic random_req();
        rpsel = 2'($urandom_range(0, 3));
        bank  = 2'($urandom_range(0, 3));
        row   = 2'($urandom_range(0, 3));
        col   = ($urandom_range(0, 7) == 0) ? 28'($urandom()) : 28'($urandom_range(0, 63));
    endtask

    task automatic fill_and_check(input int target, input bit use_pattern, input bit rand_reads,
                                  input bit rel_noise, input bit rel_on_blk, output int pulses);
        int writes, post, guard;
        bit hs;
        writes = 0; post = 0; guard = 0; pulses = 0;
        while ((writes < target || post < 3) && guard < 4000) begin
            guard++;
            if (writes < target) begin
                wvalid = ($urandom_range(0, 3) != 0);
                wdata  = use_pattern ? pattern(wcount) : 16'($urandom());
            end else begin
                wvalid = 0;
                post++;
            end
            if (rand_reads && writes < target) random_req();
            else rpsel = 2'b11;
            blk_rel = (rel_on_blk && m_blk) || (rel_noise && m_fill && $urandom_range(0, 7) == 0);
            hs = wvalid && m_wready;
            advance();
            if (hs) writes++;
            if (blkend === 1'b1) pulses++;
            checks++;
            if (wready !== m_wready) begin
                failures++; $display("FAIL fill_wready cyc=%0d: got %0b expected %0b", cyc, wready, m_wready);
            end
            checks++;
            if (blkend !== m_blk) begin
                failures++; $display("FAIL fill_blkend cyc=%0d: got %0b expected %0b", cyc, blkend, m_blk);
            end
            checks++;
            if (rvalid !== cur.valid || rerr !== cur.err || rmask !== cur.mask) begin
                failures++;
                $display("FAIL fill_rctl cyc=%0d: got v=%0b e=%0b m=%b expected v=%0b e=%0b m=%b",
                         cyc, rvalid, rerr, rmask, cur.valid, cur.err, cur.mask);
            end
            checks++;
            if (rdata !== cur.data) begin
                failures++; $display("FAIL fill_rdata cyc=%0d: got %h expected %h", cyc, rdata, cur.data);
            end
        end
        blk_rel = 0; wvalid = 0; rpsel = 2'b11;
        checks++;
        if (guard >= 4000) begin
            failures++; $display("FAIL fill_timeout: got %0d writes expected %0d", writes, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; wvalid = 0; rpsel = 2'b11; blk_rel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wready !== 1'b0) begin failures++; $display("FAIL rst_wready: got %0b expected 0", wready); end
        checks++;
        if (blkend !== 1'b0) begin failures++; $display("FAIL rst_blkend: got %0b expected 0", blkend); end
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %0b expected 0", rvalid); end
        checks++;
        if (rmask !== 3'b000) begin failures++; $display("FAIL rst_rmask: got %b expected 000", rmask); end
        checks++;
        if (rdata !== 48'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        checks++;
        if (rerr !== 1'b0) begin failures++; $display("FAIL rst_rerr: got %0b expected 0", rerr); end
        rst_n = 1;
        #1;
        checks++;
        if (wready !== 1'b0) begin failures++; $display("FAIL rst_rel_wready: got %0b expected 0", wready); end
        advance();
        checks++;
        if (wready !== 1'b1) begin failures++; $display("FAIL rst_first_fill_wready: got %0b expected 1", wready); end
    endtask

    task automatic test_fill();
        int p;
        fill_and_check(TOTAL, 1, 0, 0, 0, p);
        checks++;
        if (p != 1) begin failures++; $display("FAIL fill_blkend_pulses: got %0d expected 1", p); end
        checks++;
        if (wready !== 1'b0) begin failures++; $display("FAIL fill_ready_wready: got %0b expected 0", wready); end
    endtask

    task automatic test_rr();
        rpsel = 2'b00; row = 2; col = 28'd5; bank = 0;
        advance();
        rpsel = 2'b11;
        advance();
        advance();
        checks++;
        if (rvalid !== 1'b1 || rerr !== 1'b0) begin
            failures++; $display("FAIL rr_valid: got v=%0b e=%0b expected v=1 e=0", rvalid, rerr);
        end
        checks++;
        if (rmask !== 3'b111) begin failures++; $display("FAIL rr_mask: got %b expected 111", rmask); end
        checks++;
        if (rdata !== 48'h2205_1205_0205) begin
            failures++; $display("FAIL rr_data: got %h expected 220512050205", rdata);
        end
    endtask

    task automatic test_back_to_back();
        rpsel = 2'b01; bank = 1; row = 3; col = 28'd63;
        advance();
        rpsel = 2'b10; bank = 2; row = 0; col = 28'd0;
        advance();
        rpsel = 2'b11;
        advance();
        checks++;
        if (rvalid !== 1'b1 || rmask !== 3'b100 || rdata[47:32] !== 16'h133F || rdata[31:0] !== 32'h0) begin
            failures++; $display("FAIL b2b_br: got v=%0b m=%b d=%h expected v=1 m=100 d=133f00000000", rvalid, rmask, rdata);
        end
        advance();
        checks++;
        if (rvalid !== 1'b1 || rmask !== 3'b001 || rdata !== 48'h2000) begin
            failures++; $display("FAIL b2b_rp: got v=%0b m=%b d=%h expected v=1 m=001 d=2000", rvalid, rmask, rdata);
        end
        advance();
        checks++;
        if (rvalid !== 1'b0 || rdata !== 48'h2000) begin
            failures++; $display("FAIL b2b_ne: got v=%0b d=%h expected v=0 d=2000 (held)", rvalid, rdata);
        end
    endtask

    task automatic test_range_err();
        rpsel = 2'b10; bank = 0; row = 0; col = 28'h40;
        advance();
        rpsel = 2'b01; bank = 3; row = 1; col = 28'd7;
        advance();
        rpsel = 2'b11;
        advance();
        checks++;
        if (rvalid !== 1'b1 || rerr !== 1'b1 || rmask !== 3'b000 || rdata !== 48'h0) begin
            failures++; $display("FAIL err_col: got v=%0b e=%0b m=%b d=%h expected v=1 e=1 m=000 d=0", rvalid, rerr, rmask, rdata);
        end
        advance();
        checks++;
        if (rvalid !== 1'b1 || rerr !== 1'b1 || rmask !== 3'b000 || rdata !== 48'h0) begin
            failures++; $display("FAIL err_bank: got v=%0b e=%0b m=%b d=%h expected v=1 e=1 m=000 d=0", rvalid, rerr, rmask, rdata);
        end
        advance();
        checks++;
        if (rvalid !== 1'b0 || rerr !== 1'b0) begin
            failures++; $display("FAIL err_clear: got v=%0b e=%0b expected v=0 e=0", rvalid, rerr);
        end
    endtask

    task automatic test_random_reads();
        for (int n = 0; n < 203; n++) begin
            if (n < 200) random_req();
            else rpsel = 2'b11;
            advance();
            checks++;
            if (rvalid !== cur.valid || rerr !== cur.err || rmask !== cur.mask) begin
                failures++;
                $display("FAIL rand_rctl cyc=%0d: got v=%0b e=%0b m=%b expected v=%0b e=%0b m=%b",
                         cyc, rvalid, rerr, rmask, cur.valid, cur.err, cur.mask);
            end
            checks++;
            if (rdata !== cur.data) begin
                failures++; $display("FAIL rand_rdata cyc=%0d: got %h expected %h", cyc, rdata, cur.data);
            end
        end
    endtask

    task automatic test_release();
        int p;
        blk_rel = 1;
        advance();
        blk_rel = 0;
        checks++;
        if (wready !== 1'b1 || blkend !== 1'b0) begin
            failures++; $display("FAIL rel_to_fill: got wready=%0b blkend=%0b expected 1 0", wready, blkend);
        end
        fill_and_check(TOTAL, 0, 1, 1, 1, p);
        checks++;
        if (p != 1) begin failures++; $display("FAIL rel_fill_pulses: got %0d expected 1", p); end
        wvalid = 1; wdata = 16'hA5C3;
        advance();
        wvalid = 0;
        rpsel = 2'b10; bank = 0; row = 0; col = 28'd0;
        advance();
        rpsel = 2'b11;
        advance();
        advance();
        checks++;
        if (rvalid !== 1'b1 || rmask !== 3'b001 || rdata !== 48'hA5C3) begin
            failures++; $display("FAIL rel_first_write: got v=%0b m=%b d=%h expected v=1 m=001 d=a5c3", rvalid, rmask, rdata);
        end
    endtask

    task automatic test_reset_midfill();
        int p;
        fill_and_check(100 - wcount, 0, 1, 0, 0, p);
        rpsel = 2'b00; row = 1; col = 28'd9; wvalid = 1; wdata = 16'h7E7E;
        repeat (3) advance();
        checks++;
        if (rvalid !== 1'b1) begin failures++; $display("FAIL mid_inflight: got %0b expected 1", rvalid); end
        rst_n = 0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || blkend !== 1'b0 || wready !== 1'b0 || rmask !== 3'b000 || rerr !== 1'b0) begin
            failures++; $display("FAIL mid_rst_drop: got v=%0b b=%0b w=%0b m=%b e=%0b expected all 0",
                                 rvalid, blkend, wready, rmask, rerr);
        end
        wvalid = 0; rpsel = 2'b11;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        checks++;
        if (wready !== 1'b0) begin failures++; $display("FAIL mid_rel_wready: got %0b expected 0", wready); end
        fill_and_check(TOTAL, 0, 1, 0, 0, p);
        checks++;
        if (p != 1) begin failures++; $display("FAIL mid_refill_pulses: got %0d expected 1", p); end
        test_random_reads();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_rr();
        test_back_to_back();
        test_range_err();
        test_random_reads();
        test_release();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
